// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of the single-cycle datapath.
// Owns the PC, keeps exactly one instruction-memory read in flight, and hands
// the returned word to the datapath through a valid/ready handshake.
// A redirect loads a new PC and squashes whatever fetch is in progress.
//
// Optional build macro: FETCH_MISALIGN_TRAP_EN
//   defined   : adds fetch_misaligned; a misaligned redirect parks in HALT
//   undefined : redirect_pc[1:0] are forced to zero when loaded
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | post-reset, request goes out next cycle
// REQ    | imem_req high for this single cycle, imem_addr = pc
// WAIT   | waiting for imem_rvalid; drop=1 means the response is stale
// HOLD   | instruction valid, waiting for inst_ready
// HALT   | misaligned redirect trap, no requests (optional feature only)
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [31:0]           NOP_INST   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instruction,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [ADDR_WIDTH-1:0] pc_out,
  input  logic                  redirect_en,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                  fetch_misaligned
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  drop;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] target;

  // The request address is the PC register itself; it only changes on
  // redirect or consume, both of which leave REQ one cycle later.
  assign imem_addr = pc;
  assign pc_inc    = pc + ADDR_WIDTH'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic target_misaligned;
  assign target           = redirect_pc;
  assign target_misaligned = |redirect_pc[1:0];
`else
  assign target = redirect_pc & ~ADDR_WIDTH'(3);
`endif

  // Fetch FSM: PC, outstanding-request bookkeeping and all registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      pc_out      <= RESET_PC;
      drop        <= 1'b0;
      imem_req    <= 1'b0;
      inst_valid  <= 1'b0;
      instruction <= NOP_INST;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_misaligned <= 1'b0;
`endif
    end else begin
      imem_req <= 1'b0;
      if (redirect_en) begin
        // Redirect beats a simultaneous consume: no +4, word is squashed.
        pc          <= target;
        inst_valid  <= 1'b0;
        instruction <= NOP_INST;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (target_misaligned) begin
          fetch_misaligned <= 1'b1;
          state            <= S_HALT;
          // Remember a still-outstanding read so its response is eaten
          // even if we leave HALT before it arrives.
          case (state)
            S_REQ:   drop <= 1'b1;
            S_WAIT:  drop <= !imem_rvalid;
            S_HALT:  drop <= drop && !imem_rvalid;
            default: drop <= 1'b0;
          endcase
        end else begin
          fetch_misaligned <= 1'b0;
`endif
          case (state)
            S_REQ: begin
              drop  <= 1'b1;
              state <= S_WAIT;
            end
            S_WAIT: begin
              if (imem_rvalid) begin
                drop     <= 1'b0;
                state    <= S_REQ;
                imem_req <= 1'b1;
              end else begin
                drop  <= 1'b1;
                state <= S_WAIT;
              end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            S_HALT: begin
              if (drop && !imem_rvalid) begin
                state <= S_WAIT;
              end else begin
                drop     <= 1'b0;
                state    <= S_REQ;
                imem_req <= 1'b1;
              end
            end
`endif
            default: begin
              drop     <= 1'b0;
              state    <= S_REQ;
              imem_req <= 1'b1;
            end
          endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        end
`endif
      end else begin
        case (state)
          S_IDLE: begin
            state    <= S_REQ;
            imem_req <= 1'b1;
          end
          S_REQ: begin
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              if (drop) begin
                drop     <= 1'b0;
                state    <= S_REQ;
                imem_req <= 1'b1;
              end else begin
                instruction <= imem_rdata;
                inst_valid  <= 1'b1;
                pc_out      <= pc;
                state       <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (inst_ready) begin
              pc          <= pc_inc;
              inst_valid  <= 1'b0;
              instruction <= NOP_INST;
              state       <= S_REQ;
              imem_req    <= 1'b1;
            end
          end
          S_HALT: begin
            if (imem_rvalid) begin
              drop <= 1'b0;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table for the documented corner cases,
// an asynchronous mid-operation reset, then a randomized run against a
// transaction-level model (expected PC stream plus an address-keyed memory).
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] pc_out;
  logic        redirect_en;
  logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(
    .ADDR_WIDTH(32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INST  (NOP)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instruction(instruction),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .pc_out     (pc_out),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned(fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents are a fixed function of address, so a word fetched for
  // a squashed address can never masquerade as the word for the new PC.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic redir, input logic [31:0] rpc, input logic rdy,
                     input logic rv, input logic [31:0] rd,
                     input logic er, input logic [31:0] ea, input logic ev,
                     input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.e_req = er; v.e_addr = ea; v.e_v = ev; v.e_ins = ei; v.e_pc = ep;
    vt.push_back(v);
  endtask

  task automatic idle_inputs();
    redirect_en = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " imem_req"}, imem_req, 1'b0);
    check({tag, " imem_addr"}, imem_addr, 32'h0);
    check({tag, " inst_valid"}, inst_valid, 1'b0);
    check({tag, " instruction"}, instruction, NOP);
    check({tag, " pc_out"}, pc_out, 32'h0);
  endtask

  initial begin
    logic [31:0] m_pc;
    logic [31:0] maddr;
    bit          busy;
    int          cnt;
    int          accepts;

    idle_inputs();

    // inputs applied before an edge | outputs expected just after it
    //   redir rpc           rdy rv rdata          req addr          v  instr          pc_out
    add(0, 32'h0,         0, 0, 32'h0,        1, 32'h0,         0, NOP,          32'h0);
    add(0, 32'h0,         0, 0, 32'h0,        0, 32'h0,         0, NOP,          32'h0);
    add(0, 32'h0,         0, 1, 32'h0050_0093, 0, 32'h0,        1, 32'h0050_0093, 32'h0);
    for (int i = 0; i < 5; i++)
      add(0, 32'h0,       0, 0, 32'h0,        0, 32'h0,         1, 32'h0050_0093, 32'h0);
    add(0, 32'h0,         1, 0, 32'h0,        1, 32'h4,         0, NOP,          32'h0);
    add(0, 32'h0,         0, 0, 32'h0,        0, 32'h4,         0, NOP,          32'h0);
    add(1, 32'h100,       0, 0, 32'h0,        0, 32'h100,       0, NOP,          32'h0);
    add(0, 32'h0,         0, 0, 32'h0,        0, 32'h100,       0, NOP,          32'h0);
    add(0, 32'h0,         0, 1, 32'hDEAD_BEEF, 1, 32'h100,      0, NOP,          32'h0);
    add(0, 32'h0,         0, 0, 32'h0,        0, 32'h100,       0, NOP,          32'h0);
    add(0, 32'h0,         0, 1, 32'h1111_1111, 0, 32'h100,      1, 32'h1111_1111, 32'h100);
    add(1, 32'h40,        1, 0, 32'h0,        1, 32'h40,        0, NOP,          32'h100);
    add(0, 32'h0,         0, 0, 32'h0,        0, 32'h40,        0, NOP,          32'h100);
    add(0, 32'h0,         0, 1, 32'h2222_2222, 0, 32'h40,       1, 32'h2222_2222, 32'h40);
    add(1, 32'hFFFF_FFFC, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, NOP,          32'h40);
    add(0, 32'h0,         0, 0, 32'h0,        0, 32'hFFFF_FFFC, 0, NOP,          32'h40);
    add(0, 32'h0,         0, 1, 32'h3333_3333, 0, 32'hFFFF_FFFC, 1, 32'h3333_3333, 32'hFFFF_FFFC);
    add(0, 32'h0,         1, 0, 32'h0,        1, 32'h0,         0, NOP,          32'hFFFF_FFFC);
    add(0, 32'h0,         0, 0, 32'h0,        0, 32'h0,         0, NOP,          32'hFFFF_FFFC);
    add(1, 32'h200,       0, 1, 32'h4444_4444, 1, 32'h200,      0, NOP,          32'hFFFF_FFFC);
    add(1, 32'h300,       0, 0, 32'h0,        0, 32'h300,       0, NOP,          32'hFFFF_FFFC);
    add(0, 32'h0,         0, 1, 32'h5555_5555, 1, 32'h300,      0, NOP,          32'hFFFF_FFFC);
    add(0, 32'h0,         0, 0, 32'h0,        0, 32'h300,       0, NOP,          32'hFFFF_FFFC);
    add(0, 32'h0,         0, 1, 32'h6666_6666, 0, 32'h300,      1, 32'h6666_6666, 32'h300);
    add(0, 32'h0,         0, 1, 32'hBAD0_BAD0, 0, 32'h300,      1, 32'h6666_6666, 32'h300);
`ifdef FETCH_MISALIGN_TRAP_EN
    add(1, 32'h102,       1, 0, 32'h0,        0, 32'h102,       0, NOP,          32'h300);
`else
    add(1, 32'h402,       1, 0, 32'h0,        1, 32'h400,       0, NOP,          32'h300);
`endif

    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rstn = 1'b1;

    foreach (vt[i]) begin
      redirect_en = vt[i].redir;
      redirect_pc = vt[i].rpc;
      inst_ready  = vt[i].rdy;
      imem_rvalid = vt[i].rv;
      imem_rdata  = vt[i].rd;
      @(posedge clk);
      #1;
      check($sformatf("row%0d imem_req", i), imem_req, vt[i].e_req);
      check($sformatf("row%0d imem_addr", i), imem_addr, vt[i].e_addr);
      check($sformatf("row%0d inst_valid", i), inst_valid, vt[i].e_v);
      check($sformatf("row%0d instruction", i), instruction, vt[i].e_ins);
      check($sformatf("row%0d pc_out", i), pc_out, vt[i].e_pc);
    end
    idle_inputs();

`ifdef FETCH_MISALIGN_TRAP_EN
    check("trap flag set", fetch_misaligned, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("halt%0d no req", i), imem_req, 1'b0);
      check($sformatf("halt%0d flag", i), fetch_misaligned, 1'b1);
    end
    redirect_en = 1'b1;
    redirect_pc = 32'h104;
    @(posedge clk);
    #1;
    idle_inputs();
    check("unhalt flag", fetch_misaligned, 1'b0);
    check("unhalt req", imem_req, 1'b1);
    check("unhalt addr", imem_addr, 32'h104);
`endif

    // Asynchronous reset in WAIT, with a stale response arriving afterwards.
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_vals("async reset");
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    check_reset_vals("held reset");
    rstn = 1'b1;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    check("post reset req", imem_req, 1'b1);
    check("post reset addr", imem_addr, 32'h0);
    check("post reset valid", inst_valid, 1'b0);

    // Randomized run: the model only tracks which PC the next delivered
    // word must belong to, and a one-deep memory with random latency.
    m_pc    = 32'h0;
    busy    = 1'b0;
    cnt     = 0;
    maddr   = '0;
    accepts = 0;
    for (int c = 0; c < 3000; c++) begin
      if (inst_valid) begin
        check("rnd instruction", instruction, mem_word(pc_out));
        check("rnd pc_out", pc_out, m_pc);
      end else begin
        check("rnd nop", instruction, NOP);
      end
      if (imem_req) begin
        check("rnd one outstanding", {31'b0, busy}, 32'h0);
        check("rnd imem_addr", imem_addr, m_pc);
      end

      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(maddr);
          busy        = 1'b0;
        end
      end
      if (imem_req) begin
        busy  = 1'b1;
        cnt   = $urandom_range(1, 3);
        maddr = imem_addr;
      end

      redirect_en = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else
        redirect_pc = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      redirect_pc = redirect_pc & ~32'h3;
`endif
      inst_ready = 1'($urandom_range(0, 1));

      if (redirect_en)
        m_pc = redirect_pc & ~32'h3;
      else if (inst_valid && inst_ready) begin
        m_pc = m_pc + 32'h4;
        accepts++;
      end

      @(posedge clk);
      #1;
    end
    check("rnd progress", {31'b0, accepts >= 50}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
